thunderbird_sequencer: RTL and testbench

Central taillight controller for the Thunderbird lamp bank: a single FSM that arbitrates left-turn, right-turn and hazard requests and sequences all six lamps. It is clocked from the board clock and advanced by the one-cycle enable pulse from the clock divider. It replaces independent per-side sequencers, so left and right can never run conflicting patterns. Outputs map directly onto the six-LED lamp bank (left group high, right group low).

---
 rtl/thunderbird_sequencer.sv | 137 +++++++++++++
 tb/tb_thunderbird_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/thunderbird_sequencer.sv
// thunderbird_sequencer
//   Taillight controller for the six-lamp Thunderbird bank. One FSM arbitrates
//   left, right and hazard requests so the two sides can never run conflicting
//   patterns. All activity is qualified by the one-cycle divider pulse `tick`.
//
// Ports
//   clk         board clock
//   rst         asynchronous, active-high reset
//   tick        one-cycle enable pulse from the clock divider
//   left_req    left-turn request (level)
//   right_req   right-turn request (level)
//   hazard_req  hazard request (level)
//   lights      [5:3] left group (inner = bit 3), [2:0] right group (inner = bit 2)
//   mode        00 idle, 01 right, 10 left, 11 hazard
//   busy        high whenever the FSM is not in IDLE
//   seq_done    one-cycle pulse on the first IDLE cycle after a completed turn
//
// state   | meaning
// --------+---------------------------------------------
// IDLE    | all lamps dark, waiting for a request on a tick
// L1..L3  | left sweep, one more lamp lit per step
// R1..R3  | right sweep, one more lamp lit per step
// HAZ_ON  | hazard flash, all six lamps lit
// HAZ_OFF | hazard flash, all six lamps dark
module thunderbird_sequencer #(
  parameter int DWELL_TICKS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       left_req,
  input  logic       right_req,
  input  logic       hazard_req,
  output logic [5:0] lights,
  output logic [1:0] mode,
  output logic       busy,
  output logic       seq_done
);

  typedef enum logic [3:0] {
    IDLE, L1, L2, L3, R1, R2, R3, HAZ_ON, HAZ_OFF
  } state_t;

  localparam logic [3:0] DWELL_LAST = 4'(DWELL_TICKS - 1);

  state_t     state_q, state_d;
  logic [3:0] dwell_q, dwell_d;
  logic [5:0] lights_q, lights_d;
  logic [1:0] mode_q, mode_d;
  logic       busy_q, busy_d;
  logic       seq_done_q, seq_done_d;
  logic       haz;
  logic       step;

  always_comb begin
    // Simultaneous left and right collapses into hazard.
    haz        = hazard_req | (left_req & right_req);
    step       = tick & (dwell_q == DWELL_LAST);
    state_d    = state_q;
    dwell_d    = dwell_q;
    seq_done_d = 1'b0;

    if (state_q == IDLE) begin
      dwell_d = 4'd0;
    end else if (tick) begin
      dwell_d = step ? 4'd0 : dwell_q + 4'd1;
    end

    case (state_q)
      IDLE: begin
        if (tick) begin
          if (haz)            state_d = HAZ_ON;
          else if (left_req)  state_d = L1;
          else if (right_req) state_d = R1;
        end
      end
      // Turn sweeps ignore their own request level; only hazard can abort.
      L1: if (step) state_d = haz ? HAZ_ON : L2;
      L2: if (step) state_d = haz ? HAZ_ON : L3;
      R1: if (step) state_d = haz ? HAZ_ON : R2;
      R2: if (step) state_d = haz ? HAZ_ON : R3;
      L3, R3: begin
        if (step) begin
          if (haz) begin
            state_d = HAZ_ON;
          end else begin
            state_d    = IDLE;
            seq_done_d = 1'b1;
          end
        end
      end
      HAZ_ON:  if (step) state_d = haz ? HAZ_OFF : IDLE;
      HAZ_OFF: if (step) state_d = haz ? HAZ_ON : IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    lights_d = 6'b000_000;
    mode_d   = 2'b00;
    case (state_d)
      L1:      begin lights_d = 6'b001_000; mode_d = 2'b10; end
      L2:      begin lights_d = 6'b011_000; mode_d = 2'b10; end
      L3:      begin lights_d = 6'b111_000; mode_d = 2'b10; end
      R1:      begin lights_d = 6'b000_100; mode_d = 2'b01; end
      R2:      begin lights_d = 6'b000_110; mode_d = 2'b01; end
      R3:      begin lights_d = 6'b000_111; mode_d = 2'b01; end
      HAZ_ON:  begin lights_d = 6'b111_111; mode_d = 2'b11; end
      HAZ_OFF: begin lights_d = 6'b000_000; mode_d = 2'b11; end
      default: begin lights_d = 6'b000_000; mode_d = 2'b00; end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      dwell_q    <= 4'd0;
      lights_q   <= 6'b000_000;
      mode_q     <= 2'b00;
      busy_q     <= 1'b0;
      seq_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dwell_q    <= dwell_d;
      lights_q   <= lights_d;
      mode_q     <= mode_d;
      busy_q     <= busy_d;
      seq_done_q <= seq_done_d;
    end
  end

  assign lights   = lights_q;
  assign mode     = mode_q;
  assign busy     = busy_q;
  assign seq_done = seq_done_q;

endmodule

// File: tb/tb_thunderbird_sequencer.sv
// Scoreboard bench for thunderbird_sequencer. Three instances with dwell 1, 2
// and 3 share the stimulus; `sel` picks which one the monitor compares.
module tb_thunderbird_sequencer;

  typedef struct packed {
    logic [5:0] lights;
    logic [1:0] mode;
    logic       busy;
    logic       seq_done;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       left_req = 1'b0;
  logic       right_req = 1'b0;
  logic       hazard_req = 1'b0;
  logic [5:0] lights_w [3];
  logic [1:0] mode_w [3];
  logic       busy_w [3];
  logic       done_w [3];
  int         sel = 0;
  int         errors = 0;
  int         checks = 0;
  exp_t       exp_q [$];
  exp_t       last = '0;
  logic       tick_at_edge = 1'b0;

  always #5 clk = ~clk;

  thunderbird_sequencer #(.DWELL_TICKS(1)) u_d1 (
    .clk(clk), .rst(rst), .tick(tick), .left_req(left_req), .right_req(right_req),
    .hazard_req(hazard_req), .lights(lights_w[0]), .mode(mode_w[0]), .busy(busy_w[0]),
    .seq_done(done_w[0]));
  thunderbird_sequencer #(.DWELL_TICKS(2)) u_d2 (
    .clk(clk), .rst(rst), .tick(tick), .left_req(left_req), .right_req(right_req),
    .hazard_req(hazard_req), .lights(lights_w[1]), .mode(mode_w[1]), .busy(busy_w[1]),
    .seq_done(done_w[1]));
  thunderbird_sequencer #(.DWELL_TICKS(3)) u_d3 (
    .clk(clk), .rst(rst), .tick(tick), .left_req(left_req), .right_req(right_req),
    .hazard_req(hazard_req), .lights(lights_w[2]), .mode(mode_w[2]), .busy(busy_w[2]),
    .seq_done(done_w[2]));

  function automatic exp_t actual();
    exp_t a;
    a.lights   = lights_w[sel];
    a.mode     = mode_w[sel];
    a.busy     = busy_w[sel];
    a.seq_done = done_w[sel];
    return a;
  endfunction

  task automatic compare(input string name, input exp_t act, input exp_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t dut=%0d: got lights=%b mode=%b busy=%b done=%b, want lights=%b mode=%b busy=%b done=%b",
               name, $time, sel, act.lights, act.mode, act.busy, act.seq_done,
               exp.lights, exp.mode, exp.busy, exp.seq_done);
    end
  endtask

  always @(posedge clk) tick_at_edge <= tick && !rst;

  // Monitor: a tick edge means the DUT presents a new response; otherwise the
  // outputs must hold and seq_done must be low.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        last = '0;
      end else if (tick_at_edge) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_underflow t=%0t: response with no expectation queued", $time);
        end else begin
          e = exp_q.pop_front();
          compare("tick_response", actual(), e);
          last = e;
          last.seq_done = 1'b0;
        end
      end else begin
        compare("hold_between_ticks", actual(), last);
      end
    end
  end

  task automatic do_tick(input logic [5:0] l, input logic [1:0] m, input logic d);
    exp_t e;
    e.lights   = l;
    e.mode     = m;
    e.busy     = (m != 2'b00);
    e.seq_done = d;
    exp_q.push_back(e);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset(input int which);
    left_req   = 1'b0;
    right_req  = 1'b0;
    hazard_req = 1'b0;
    tick       = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    sel = which;
    #1;
    compare("reset_state", actual(), exp_t'(0));
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "bench timed out");
  end

  initial begin
    // Dwell 1, left held: two complete sweeps.
    do_reset(0);
    left_req = 1'b1;
    for (int r = 0; r < 2; r++) begin
      do_tick(6'b001_000, 2'b10, 1'b0);
      do_tick(6'b011_000, 2'b10, 1'b0);
      do_tick(6'b111_000, 2'b10, 1'b0);
      do_tick(6'b000_000, 2'b00, 1'b1);
    end
    left_req = 1'b0;
    do_tick(6'b000_000, 2'b00, 1'b0);

    // Dwell 2, right pulsed for the first tick only.
    do_reset(1);
    right_req = 1'b1;
    do_tick(6'b000_100, 2'b01, 1'b0);
    right_req = 1'b0;
    do_tick(6'b000_100, 2'b01, 1'b0);
    do_tick(6'b000_110, 2'b01, 1'b0);
    do_tick(6'b000_110, 2'b01, 1'b0);
    do_tick(6'b000_111, 2'b01, 1'b0);
    do_tick(6'b000_111, 2'b01, 1'b0);
    do_tick(6'b000_000, 2'b00, 1'b1);
    do_tick(6'b000_000, 2'b00, 1'b0);

    // Dwell 1, left and right both held: hazard flash.
    do_reset(0);
    left_req  = 1'b1;
    right_req = 1'b1;
    for (int r = 0; r < 2; r++) begin
      do_tick(6'b111_111, 2'b11, 1'b0);
      do_tick(6'b000_000, 2'b11, 1'b0);
    end
    left_req  = 1'b0;
    right_req = 1'b0;
    do_tick(6'b000_000, 2'b00, 1'b0);

    // Dwell 1, hazard arrives during L2 and aborts the sweep.
    do_reset(0);
    left_req = 1'b1;
    do_tick(6'b001_000, 2'b10, 1'b0);
    do_tick(6'b011_000, 2'b10, 1'b0);
    hazard_req = 1'b1;
    do_tick(6'b111_111, 2'b11, 1'b0);
    hazard_req = 1'b0;
    do_tick(6'b000_000, 2'b00, 1'b0);
    left_req = 1'b0;

    // Dwell 1, right requested during L1: left completes, then right runs.
    do_reset(0);
    left_req = 1'b1;
    do_tick(6'b001_000, 2'b10, 1'b0);
    left_req  = 1'b0;
    right_req = 1'b1;
    do_tick(6'b011_000, 2'b10, 1'b0);
    do_tick(6'b111_000, 2'b10, 1'b0);
    do_tick(6'b000_000, 2'b00, 1'b1);
    do_tick(6'b000_100, 2'b01, 1'b0);
    right_req = 1'b0;
    do_tick(6'b000_110, 2'b01, 1'b0);
    do_tick(6'b000_111, 2'b01, 1'b0);
    do_tick(6'b000_000, 2'b00, 1'b1);

    // Dwell 3, async reset in R2 with one tick counted, then a fresh left sweep.
    do_reset(2);
    right_req = 1'b1;
    do_tick(6'b000_100, 2'b01, 1'b0);
    do_tick(6'b000_100, 2'b01, 1'b0);
    do_tick(6'b000_100, 2'b01, 1'b0);
    do_tick(6'b000_110, 2'b01, 1'b0);
    do_tick(6'b000_110, 2'b01, 1'b0);
    right_req = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1 compare("async_reset_immediate", actual(), exp_t'(0));
    @(negedge clk);
    tick = 1'b1;
    repeat (2) @(negedge clk);
    tick = 1'b0;
    #2 rst = 1'b0;
    @(negedge clk);
    left_req = 1'b1;
    do_tick(6'b001_000, 2'b10, 1'b0);
    do_tick(6'b001_000, 2'b10, 1'b0);
    do_tick(6'b001_000, 2'b10, 1'b0);
    do_tick(6'b011_000, 2'b10, 1'b0);
    left_req = 1'b0;

    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
